// File: rtl/hist_pkg.sv
// Shared types and helpers for the histogram accumulator slice.
// Holds the histogram geometry, the count-vector type and the group FSM states.
// Ports: none (package).
package hist_pkg;

  localparam int NUM_POS = 16;  // bit positions in one histogram beat
  localparam int CNT_W   = 6;   // signed count per position, -16..+16
  localparam int WSUM_W  = 22;  // exact width of sum(count[p] * 2^p)

  // Element p carries the signed count for bit position p (weight 2^p).
  typedef logic signed [NUM_POS-1:0][CNT_W-1:0] hist_vec_t;

  // IDLE: no partial group held. ACCUM: Acc holds a partial group.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } group_state_e;

  // Sign-extend one count to the weighted-sum width.
  function automatic logic signed [WSUM_W-1:0] sext_cnt(input logic [CNT_W-1:0] cnt);
    return WSUM_W'(signed'(cnt));
  endfunction

endpackage

// File: rtl/histogram_weighted_sum.sv
// Purpose: reduce one histogram beat to sum_p count[p] * 2^p.
// Latency: combinational. Backpressure: none, pure function of countVec.
// Ports: countVec (NUM_POS signed counts) -> weightedSum (signed WSUM_W, exact).
module histogram_weighted_sum
  import hist_pkg::*;
(
  input  hist_vec_t                countVec,
  output logic signed [WSUM_W-1:0] weightedSum
);

  // Worst case magnitude is 16 * (2^16 - 1), which fits in 22 signed bits,
  // so no term or partial sum can overflow.
  always_comb begin
    weightedSum = '0;
    for (int p = 0; p < NUM_POS; p++) begin
      weightedSum = weightedSum + (sext_cnt(countVec[p]) <<< p);
    end
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Purpose: weight, plane-shift and accumulate histogram beats into one signed sum per group.
// Latency: last beat accepted at edge k -> OutValid high after edge k+1 (2 cycles).
// Backpressure: InReady drops only while a last beat waits in S1 behind an unconsumed result.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   BeforeAllignmentVector   per-position signed counts of this beat
//   PlaneShift               left shift applied to this beat's weighted sum
//   InLast/InValid/InReady   beat closes group / beat present / beat accepted
//   OutData/OutBeats         signed group result / beats in group (saturates at 15)
//   OutValid/OutReady        result handshake
module histogram_accumulator
  import hist_pkg::*;
#(
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  hist_vec_t          BeforeAllignmentVector,
  input  logic [SHIFT_W-1:0] PlaneShift,
  input  logic               InLast,
  input  logic               InValid,
  output logic               InReady,
  output logic [ACC_W-1:0]   OutData,
  output logic [3:0]         OutBeats,
  output logic               OutValid,
  input  logic               OutReady
);

  localparam logic [3:0] BEATS_MAX = 4'd15;

  // ---------------------------------------------------------------- S1
  logic signed [WSUM_W-1:0] wSum;
  logic signed [WSUM_W-1:0] s1Sum;
  logic [SHIFT_W-1:0]       s1Shift;
  logic                     s1Last;
  logic                     s1Valid;

  logic stall;
  logic inAccept;
  logic s2Fire;
  logic commit;

  histogram_weighted_sum uWeightedSum (
    .countVec    (BeforeAllignmentVector),
    .weightedSum (wSum)
  );

  // Only a group-closing beat needs the output register, so only it can stall.
  assign stall    = s1Valid && s1Last && OutValid && !OutReady;
  assign InReady  = !rst && !stall;
  assign inAccept = InValid && InReady;
  assign s2Fire   = s1Valid && !stall;
  assign commit   = s2Fire && s1Last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Sum   <= '0;
      s1Shift <= '0;
      s1Last  <= 1'b0;
    end else if (!stall) begin
      s1Valid <= inAccept;
      if (inAccept) begin
        s1Sum   <= wSum;
        s1Shift <= PlaneShift;
        s1Last  <= InLast;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  group_state_e groupState;
  group_state_e nextGroupState;
  logic                    inGroup;
  logic signed [ACC_W-1:0] acc;
  logic [3:0]              beats;
  logic signed [ACC_W-1:0] termExt;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] newAcc;
  logic [3:0]              newBeats;

  assign inGroup = (groupState == ACCUM);

  // Sign-extend before shifting so negative sums keep their sign; any
  // carry beyond ACC_W wraps.
  assign termExt = ACC_W'(s1Sum);
  assign term    = termExt <<< s1Shift;

  always_comb begin
    newAcc   = term;
    newBeats = 4'd1;
    if (inGroup) begin
      newAcc   = acc + term;
      newBeats = (beats == BEATS_MAX) ? beats : beats + 4'd1;
    end
  end

  always_comb begin
    nextGroupState = groupState;
    if (s2Fire) begin
      nextGroupState = s1Last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      groupState <= IDLE;
    end else begin
      groupState <= nextGroupState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      beats <= '0;
    end else if (s2Fire) begin
      acc   <= s1Last ? '0 : newAcc;
      beats <= s1Last ? '0 : newBeats;
    end
  end

  // ---------------------------------------------------------------- output register
  // A commit on the same edge as a pop replaces the result and keeps OutValid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      OutData  <= '0;
      OutBeats <= '0;
      OutValid <= 1'b0;
    end else if (commit) begin
      OutData  <= newAcc;
      OutBeats <= newBeats;
      OutValid <= 1'b1;
    end else if (OutValid && OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench for histogram_accumulator: directed vectors with known
// results plus randomized groups checked against an arithmetic reference model.
module tb_histogram_accumulator;
  import hist_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  hist_vec_t   vec;
  logic [2:0]  shift;
  logic        inLast;
  logic        inValid;
  logic        inReady;
  logic [31:0] outData;
  logic [3:0]  outBeats;
  logic        outValid;
  logic        outReady;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    int          beats;
  } res_t;

  res_t obsQ[$];
  res_t expQ[$];

  always #5 clk = ~clk;

  histogram_accumulator dut (
    .clk                    (clk),
    .rst                    (rst),
    .BeforeAllignmentVector (vec),
    .PlaneShift             (shift),
    .InLast                 (inLast),
    .InValid                (inValid),
    .InReady                (inReady),
    .OutData                (outData),
    .OutBeats               (outBeats),
    .OutValid               (outValid),
    .OutReady               (outReady)
  );

  // Every consumed result, sampled mid-cycle just before the consuming edge.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) obsQ.push_back('{data: outData, beats: int'(outBeats)});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- reference model
  function automatic longint beat_value(input hist_vec_t v, input int sh);
    longint s;
    logic signed [CNT_W-1:0] c;
    s = 0;
    for (int p = 0; p < NUM_POS; p++) begin
      c = v[p];
      s += longint'(c) * (longint'(1) << p);
    end
    return s * (longint'(1) << sh);
  endfunction

  function automatic hist_vec_t one_count(input int pos, input int val);
    hist_vec_t v;
    v = '0;
    v[pos] = CNT_W'(val);
    return v;
  endfunction

  function automatic hist_vec_t all_count(input int val);
    hist_vec_t v;
    for (int p = 0; p < NUM_POS; p++) v[p] = CNT_W'(val);
    return v;
  endfunction

  // ---------------------------------------------------------------- drive helpers
  // All helpers start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    inValid = 1'b0;
    inLast  = 1'b0;
    vec     = '0;
    shift   = '0;
  endtask

  task automatic drive_beat(input hist_vec_t v, input int sh, input bit last, output int waited);
    bit rdy;
    vec     = v;
    shift   = 3'(sh);
    inLast  = last;
    inValid = 1'b1;
    waited  = 0;
    rdy     = 1'b0;
    do begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 200);
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL accept_timeout: beat not accepted after %0d cycles (required acceptance)", waited);
    end
  endtask

  task automatic wait_results(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obsQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    outReady = 1'b0;
    idle();
    tick(3);
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0) begin
      failures++;
      $display("FAIL reset_inready: got %b required 0", inReady);
    end
    checks++;
    if (outValid !== 1'b0 || outData !== 32'd0 || outBeats !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%0d beats=%0d required 0/0/0",
               outValid, outData, outBeats);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_inready: got %b required 1", inReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_latency();
    int w;
    outReady = 1'b1;
    obsQ.delete();
    drive_beat(one_count(0, 1), 0, 1'b1, w);
    idle();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: OutValid got %b one cycle after accept, required 0", outValid);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1 || $signed(outData) !== 32'sd1 || outBeats !== 4'd1) begin
      failures++;
      $display("FAIL latency_result: got valid=%b data=%0d beats=%0d required 1/1/1",
               outValid, $signed(outData), outBeats);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || obsQ.size() != 1) begin
      failures++;
      $display("FAIL pop_clear: got valid=%b pops=%0d required 0/1", outValid, obsQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed_values();
    hist_vec_t          tv[3];
    int                 ts[3];
    logic signed [31:0] te[3];
    int w;
    bit ok;
    tv[0] = one_count(15, -16); ts[0] = 7; te[0] = -67108864;
    tv[1] = all_count(16);      ts[1] = 0; te[1] = 1048560;
    tv[2] = all_count(-16);     ts[2] = 7; te[2] = -134215680;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      obsQ.delete();
      drive_beat(tv[i], ts[i], 1'b1, w);
      idle();
      wait_results(1, ok);
      checks++;
      if (!ok || obsQ[0].data !== te[i] || obsQ[0].beats != 1) begin
        failures++;
        if (ok) $display("FAIL directed_%0d: got data=%0d beats=%0d required %0d/1",
                         i, $signed(obsQ[0].data), obsQ[0].beats, te[i]);
        else    $display("FAIL directed_%0d: no result, required %0d/1", i, te[i]);
      end
      tick(2);
    end
  endtask

  task automatic test_back_to_back();
    int w[3];
    bit ok;
    outReady = 1'b1;
    obsQ.delete();
    drive_beat(one_count(3, 2), 0, 1'b0, w[0]);
    drive_beat(one_count(3, 2), 1, 1'b0, w[1]);
    drive_beat(one_count(0, -5), 0, 1'b1, w[2]);
    idle();
    checks++;
    if (w[0] != 1 || w[1] != 1 || w[2] != 1) begin
      failures++;
      $display("FAIL throughput: accept cycles got %0d,%0d,%0d required 1,1,1", w[0], w[1], w[2]);
    end
    wait_results(1, ok);
    checks++;
    if (!ok || $signed(obsQ[0].data) !== 32'sd43 || obsQ[0].beats != 3) begin
      failures++;
      if (ok) $display("FAIL three_beats: got data=%0d beats=%0d required 43/3",
                       $signed(obsQ[0].data), obsQ[0].beats);
      else    $display("FAIL three_beats: no result, required 43/3");
    end
    tick(2);
  endtask

  task automatic test_backpressure();
    int w;
    bit ok;
    outReady = 1'b0;
    obsQ.delete();
    drive_beat(one_count(0, 7), 0, 1'b1, w);
    drive_beat(one_count(0, 9), 0, 1'b1, w);
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1 || $signed(outData) !== 32'sd7 || inReady !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: got valid=%b data=%0d inReady=%b required 1/7/0",
                 i, outValid, $signed(outData), inReady);
      end
      @(posedge clk);
      #1;
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (outValid !== 1'b1 || $signed(outData) !== 32'sd9) begin
      failures++;
      $display("FAIL pop_and_commit: got valid=%b data=%0d required 1/9", outValid, $signed(outData));
    end
    @(posedge clk);
    #1;
    wait_results(2, ok);
    tick(3);
    checks++;
    if (!ok || obsQ.size() != 2) begin
      failures++;
      $display("FAIL bp_count: got %0d results required 2", obsQ.size());
    end else begin
      checks++;
      if ($signed(obsQ[0].data) !== 32'sd7 || $signed(obsQ[1].data) !== 32'sd9 ||
          obsQ[0].beats != 1 || obsQ[1].beats != 1) begin
        failures++;
        $display("FAIL bp_order: got %0d/%0d then %0d/%0d required 7/1 then 9/1",
                 $signed(obsQ[0].data), obsQ[0].beats, $signed(obsQ[1].data), obsQ[1].beats);
      end
    end
  endtask

  task automatic test_rst_midgroup();
    int w;
    bit ok;
    outReady = 1'b1;
    obsQ.delete();
    drive_beat(one_count(0, 5), 0, 1'b0, w);
    drive_beat(one_count(0, 5), 0, 1'b0, w);
    idle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b0) begin
      failures++;
      $display("FAIL rst_inready: got %b required 0", inReady);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_beat(one_count(1, 1), 0, 1'b1, w);
    idle();
    wait_results(1, ok);
    tick(3);
    checks++;
    if (!ok || obsQ.size() != 1 || $signed(obsQ[0].data) !== 32'sd2 || obsQ[0].beats != 1) begin
      failures++;
      if (ok) $display("FAIL rst_midgroup: got %0d results, first %0d/%0d required 1 result 2/1",
                       obsQ.size(), $signed(obsQ[0].data), obsQ[0].beats);
      else    $display("FAIL rst_midgroup: no result, required 2/1");
    end
  endtask

  task automatic test_saturate();
    int w;
    bit ok;
    outReady = 1'b1;
    obsQ.delete();
    for (int i = 0; i < 17; i++) drive_beat(one_count(0, 1), 0, (i == 16), w);
    idle();
    wait_results(1, ok);
    checks++;
    if (!ok || $signed(obsQ[0].data) !== 32'sd17 || obsQ[0].beats != 15) begin
      failures++;
      if (ok) $display("FAIL beats_saturate: got data=%0d beats=%0d required 17/15",
                       $signed(obsQ[0].data), obsQ[0].beats);
      else    $display("FAIL beats_saturate: no result, required 17/15");
    end
    tick(2);
  endtask

  task automatic test_random();
    bit randActive;
    bit ok;
    obsQ.delete();
    expQ.delete();
    randActive = 1'b1;
    fork
      begin
        int n, w, sh;
        longint sum;
        hist_vec_t v;
        for (int g = 0; g < 40; g++) begin
          n = $urandom_range(1, 8);
          sum = 0;
          for (int b = 0; b < n; b++) begin
            for (int p = 0; p < NUM_POS; p++) v[p] = CNT_W'(int'($urandom_range(0, 32)) - 16);
            sh = $urandom_range(0, 7);
            sum += beat_value(v, sh);
            drive_beat(v, sh, (b == n - 1), w);
            if ($urandom_range(0, 3) == 0) begin
              idle();
              tick($urandom_range(1, 2));
            end
          end
          expQ.push_back('{data: 32'(sum), beats: (n > 15) ? 15 : n});
        end
        idle();
        randActive = 1'b0;
      end
      begin
        while (randActive) begin
          outReady = ($urandom_range(0, 2) != 0);
          tick(1);
        end
      end
    join
    outReady = 1'b1;
    wait_results(expQ.size(), ok);
    tick(3);
    checks++;
    if (!ok || obsQ.size() != expQ.size()) begin
      failures++;
      $display("FAIL random_count: got %0d results required %0d", obsQ.size(), expQ.size());
    end else begin
      for (int i = 0; i < expQ.size(); i++) begin
        checks++;
        if (obsQ[i].data !== expQ[i].data || obsQ[i].beats != expQ[i].beats) begin
          failures++;
          $display("FAIL random_group_%0d: got data=%0d beats=%0d required %0d/%0d", i,
                   $signed(obsQ[i].data), obsQ[i].beats, $signed(expQ[i].data), expQ[i].beats);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_directed_values();
    test_back_to_back();
    test_backpressure();
    test_rst_midgroup();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
